fft_result_pingpong_buf: RTL and testbench

- Double-buffered store for FFT magnitude frames. Replaces the static preloaded result ROM.
- The FFT magnitude stage writes one frame of NUM_BINS bins into one bank, while a downstream consumer streams the other bank out over a valid/ready handshake.
- Tracks the peak bin of each written frame and reports it on frame completion.

---
 rtl/fft_result_pingpong_buf_pkg.sv | 19 +
 rtl/fft_result_pingpong_buf_if.sv | 28 ++
 rtl/fft_result_pingpong_buf_ram.sv | 21 ++
 rtl/fft_result_pingpong_buf.sv | 176 +++++++++++++++++
 tb/tb_fft_result_pingpong_buf.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_result_pingpong_buf_pkg.sv
// Shared types and defaults for the FFT result ping-pong buffer.
// Bank state encoding plus the bank-toggle helper used by reader and writer.
package fft_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  localparam int DEF_DATA_WIDTH = 26;
  localparam int DEF_ADDR_WIDTH = 13;

  function automatic logic other_bank(input logic bank);
    return ~bank;
  endfunction

endpackage

// File: rtl/fft_result_pingpong_buf_if.sv
// Write (FFT magnitude) and read (consumer) handshakes of the ping-pong buffer.
// slave is the buffer's view, master is the producer/consumer view.
interface fft_result_pingpong_buf_if #(
  parameter int DATA_WIDTH = 26,
  parameter int ADDR_WIDTH = 13
) ();
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] rd_bin;
  logic                  rd_last;
  logic                  frame_done;
  logic [DATA_WIDTH-1:0] peak_mag;
  logic [ADDR_WIDTH-1:0] peak_bin;

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, rd_bin, rd_last, frame_done, peak_mag, peak_bin
  );

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, rd_bin, rd_last, frame_done, peak_mag, peak_bin
  );
endinterface

// File: rtl/fft_result_pingpong_buf_ram.sv
// Simple dual-port RAM holding both banks; the bank bit is the address MSB.
// Registered read data, no reset on the array.
module fft_bin_ram #(
  parameter int DATA_WIDTH = 26,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH:0]   waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH:0]   raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**(ADDR_WIDTH+1)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_result_pingpong_buf.sv
// Double-buffered FFT magnitude store: one bank fills while the other streams out,
// with per-frame peak tracking reported on frame completion.
module fft_result_pingpong_buf
  import fft_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_BINS   = 8192
) (
  input logic                     clk,
  input logic                     rst_n,
  fft_result_pingpong_buf_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(NUM_BINS - 1);

  bank_state_t           bank_st [2];
  bank_state_t           bank_nxt [2];
  logic                  wr_bank, wr_bank_nxt, rd_bank, rd_bank_nxt;
  logic                  rd_active, rd_active_nxt, rd_issued;
  logic [ADDR_WIDTH-1:0] wr_cnt, rd_cnt, run_bin, bin_p1;
  logic [DATA_WIDTH-1:0] run_max, data_p1;
  logic                  vld_p1, last_p1;
  logic [DATA_WIDTH-1:0] sk_data [2];
  logic [ADDR_WIDTH-1:0] sk_bin [2];
  logic [1:0]            sk_last, sk_cnt;
  logic                  sk_wptr, sk_rptr;
  logic                  wr_ready, wr_fire, wr_last;
  logic                  rd_valid, rd_pop, rd_free, rd_start, rd_space, rd_issue;

  assign wr_ready = (bank_st[wr_bank] == FILLING);
  assign wr_fire  = bus.wr_valid & wr_ready;
  assign wr_last  = wr_fire && (wr_cnt == LAST_BIN);
  assign rd_valid = (sk_cnt != 2'd0);
  assign rd_pop   = rd_valid & bus.rd_ready;
  assign rd_free  = rd_pop & sk_last[sk_rptr];
  assign rd_start = !rd_active && (bank_st[rd_bank] == FULL);
  // Skid credit counts the read already in flight in the RAM output register.
  assign rd_space = ((sk_cnt + {1'b0, vld_p1}) != 2'd2) || rd_pop;
  assign rd_issue = (rd_active || rd_start) && !rd_issued && rd_space;

  // Bank ownership: the reader's release is applied before the writer's claim.
  always_comb begin
    bank_nxt[0]   = bank_st[0];
    bank_nxt[1]   = bank_st[1];
    wr_bank_nxt   = wr_bank;
    rd_bank_nxt   = rd_bank;
    rd_active_nxt = rd_active;
    if (rd_free) begin
      bank_nxt[rd_bank] = EMPTY;
      rd_bank_nxt       = other_bank(rd_bank);
      rd_active_nxt     = 1'b0;
      if (bank_st[other_bank(rd_bank)] == FULL) begin
        bank_nxt[other_bank(rd_bank)] = DRAINING;
        rd_active_nxt                 = 1'b1;
      end
    end else if (rd_start) begin
      bank_nxt[rd_bank] = DRAINING;
      rd_active_nxt     = 1'b1;
    end
    if (wr_last) begin
      bank_nxt[wr_bank] = FULL;
      wr_bank_nxt       = other_bank(wr_bank);
    end
    if (bank_nxt[wr_bank_nxt] == EMPTY) bank_nxt[wr_bank_nxt] = FILLING;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      rd_active  <= 1'b0;
    end else begin
      bank_st[0] <= bank_nxt[0];
      bank_st[1] <= bank_nxt[1];
      wr_bank    <= wr_bank_nxt;
      rd_bank    <= rd_bank_nxt;
      rd_active  <= rd_active_nxt;
    end
  end

  // Write side: bin counter, running peak, frame result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt       <= '0;
      run_max      <= '0;
      run_bin      <= '0;
      bus.peak_mag <= '0;
      bus.peak_bin <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= wr_last;
      if (wr_fire) begin
        wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
        if ((wr_cnt == '0) || (bus.wr_data > run_max)) begin
          run_max <= bus.wr_data;
          run_bin <= wr_cnt;
        end
      end
      if (wr_last) begin
        if (bus.wr_data > run_max) begin
          bus.peak_mag <= bus.wr_data;
          bus.peak_bin <= wr_cnt;
        end else begin
          bus.peak_mag <= run_max;
          bus.peak_bin <= run_bin;
        end
      end
    end
  end

  fft_bin_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr ({wr_bank, wr_cnt}),
    .wdata (bus.wr_data),
    .re    (rd_issue),
    .raddr ({rd_bank, rd_cnt}),
    .rdata (data_p1)
  );

  // Stage p1: RAM read in flight, tagged with its bin index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt    <= '0;
      rd_issued <= 1'b0;
      vld_p1    <= 1'b0;
      bin_p1    <= '0;
      last_p1   <= 1'b0;
    end else begin
      vld_p1 <= rd_issue;
      if (rd_issue) begin
        bin_p1  <= rd_cnt;
        last_p1 <= (rd_cnt == LAST_BIN);
      end
      if (rd_free) begin
        rd_cnt    <= '0;
        rd_issued <= 1'b0;
      end else if (rd_issue) begin
        rd_cnt    <= (rd_cnt == LAST_BIN) ? '0 : rd_cnt + 1'b1;
        rd_issued <= (rd_cnt == LAST_BIN);
      end
    end
  end

  // Output skid: two entries keep full rate across the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sk_data[0] <= '0;
      sk_data[1] <= '0;
      sk_bin[0]  <= '0;
      sk_bin[1]  <= '0;
      sk_last    <= '0;
      sk_wptr    <= 1'b0;
      sk_rptr    <= 1'b0;
      sk_cnt     <= '0;
    end else begin
      if (vld_p1) begin
        sk_data[sk_wptr] <= data_p1;
        sk_bin[sk_wptr]  <= bin_p1;
        sk_last[sk_wptr] <= last_p1;
        sk_wptr          <= ~sk_wptr;
      end
      if (rd_pop) sk_rptr <= ~sk_rptr;
      sk_cnt <= sk_cnt + {1'b0, vld_p1} - {1'b0, rd_pop};
    end
  end

  assign bus.wr_ready = wr_ready;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = sk_data[sk_rptr];
  assign bus.rd_bin   = sk_bin[sk_rptr];
  assign bus.rd_last  = rd_valid & sk_last[sk_rptr];

endmodule

// File: tb/tb_fft_result_pingpong_buf.sv
// Directed bench for the FFT result ping-pong buffer (8 bins, 3-bit bins, 8-bit data).
// Written bins go to a scoreboard queue and are compared as the consumer accepts them.
module tb_fft_result_pingpong_buf;
  import fft_buf_pkg::*;

  typedef logic [7:0] frame_t [8];
  typedef struct {
    logic [2:0] bin;
    logic [7:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   beats = 0;
  int   fd_cnt = 0;
  bit   rand_rd = 1'b0;
  beat_t sb [$];
  logic [2:0] wr_idx = '0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic [2:0] prev_bin = '0;

  fft_result_pingpong_buf_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  fft_result_pingpong_buf #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_BINS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      wr_idx     = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(bus.rd_valid), 32'd1);
        check("hold_data", 32'(bus.rd_data), 32'(prev_data));
        check("hold_bin", 32'(bus.rd_bin), 32'(prev_bin));
      end
      if (bus.rd_valid && bus.rd_ready) begin
        beats++;
        tests++;
        assert (sb.size() != 0) else begin
          fails++;
          $error("FAIL extra_beat: observed bin %0d data %0h expected no beat", bus.rd_bin, bus.rd_data);
        end
        if (sb.size() != 0) begin
          beat_t e;
          e = sb.pop_front();
          check("rd_data", 32'(bus.rd_data), 32'(e.data));
          check("rd_bin", 32'(bus.rd_bin), 32'(e.bin));
          check("rd_last", 32'(bus.rd_last), 32'(e.bin == 3'd7));
        end
      end
      if (bus.wr_valid && bus.wr_ready) begin
        beat_t n;
        n.bin  = wr_idx;
        n.data = bus.wr_data;
        sb.push_back(n);
        wr_idx = wr_idx + 3'd1;
      end
      if (bus.frame_done) fd_cnt++;
      prev_stall = bus.rd_valid && !bus.rd_ready;
      prev_data  = bus.rd_data;
      prev_bin   = bus.rd_bin;
    end
  end

  task automatic write_bin(input logic [7:0] d, output int waits);
    bit ok;
    waits = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    forever begin
      @(negedge clk);
      ok = bus.wr_ready;
      @(posedge clk);
      #1;
      if (rand_rd) bus.rd_ready = 1'($urandom_range(0, 1));
      if (ok) break;
      waits++;
      if (waits > 200) begin
        check("wr_timeout", 32'(waits), 32'd0);
        break;
      end
    end
  endtask

  task automatic write_frame(input frame_t f, input bit keep);
    int w;
    for (int i = 0; i < 8; i++) write_bin(f[i], w);
    if (!keep) bus.wr_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.rd_valid) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (rand_rd) bus.rd_ready = 1'($urandom_range(0, 1));
    end
    check("drain_done", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic void peak_of(input frame_t f, output logic [7:0] m, output logic [2:0] b);
    m = f[0];
    b = 3'd0;
    for (int i = 1; i < 8; i++) if (f[i] > m) begin
      m = f[i];
      b = 3'(i);
    end
  endfunction

  task automatic check_peak(input logic [7:0] m, input logic [2:0] b);
    @(negedge clk);
    check("frame_done", 32'(bus.frame_done), 32'd1);
    check("peak_mag", 32'(bus.peak_mag), 32'(m));
    check("peak_bin", 32'(bus.peak_bin), 32'(b));
    @(posedge clk);
    #1;
  endtask

  initial begin
    frame_t     f;
    logic [7:0] em;
    logic [2:0] eb;
    int         w, fd0, b0;
    bit         found;

    rst_n = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_rd_bin", 32'(bus.rd_bin), 32'd0);
    check("rst_rd_last", 32'(bus.rd_last), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("rst_peak_mag", 32'(bus.peak_mag), 32'd0);
    check("rst_peak_bin", 32'(bus.peak_bin), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("wr_ready_after_rst", 32'(bus.wr_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single frame, consumer always ready.
    bus.rd_ready = 1'b1;
    fd0 = fd_cnt;
    b0  = beats;
    f = '{8'd5, 8'd9, 8'd3, 8'd9, 8'd1, 8'd0, 8'd2, 8'd7};
    write_frame(f, 1'b0);
    @(negedge clk);
    check("t1_frame_done", 32'(bus.frame_done), 32'd1);
    check("t1_peak_mag", 32'(bus.peak_mag), 32'd9);
    check("t1_peak_bin", 32'(bus.peak_bin), 32'd1);
    check("t1_lat_e0", 32'(bus.rd_valid), 32'd0);
    @(negedge clk);
    check("t1_lat_e1", 32'(bus.rd_valid), 32'd0);
    check("t1_done_pulse", 32'(bus.frame_done), 32'd0);
    @(negedge clk);
    check("t1_lat_e2", 32'(bus.rd_valid), 32'd1);
    @(posedge clk);
    #1;
    drain();
    check("t1_fd_count", 32'(fd_cnt - fd0), 32'd1);
    check("t1_beats", 32'(beats - b0), 32'd8);

    // Consumer stalled: two frames fill both banks, writer stalls.
    bus.rd_ready = 1'b0;
    fd0 = fd_cnt;
    b0  = beats;
    for (int i = 0; i < 16; i++) write_bin(8'(i * 13 + 1), w);
    bus.wr_data = 8'hC0;
    repeat (5) begin
      @(negedge clk);
      check("t2_stall", 32'(bus.wr_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.rd_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.rd_valid && bus.rd_last) begin
        found = 1'b1;
        check("t2_ready_before_free", 32'(bus.wr_ready), 32'd0);
        break;
      end
      @(posedge clk);
      #1;
    end
    check("t2_free_seen", 32'(found), 32'd1);
    @(negedge clk);
    check("t2_ready_after_free", 32'(bus.wr_ready), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 1; i < 8; i++) write_bin(8'(8'hC0 + i), w);
    bus.wr_valid = 1'b0;
    drain();
    check("t2_fd_count", 32'(fd_cnt - fd0), 32'd3);
    check("t2_beats", 32'(beats - b0), 32'd24);

    // Random consumer backpressure over four frames.
    rand_rd = 1'b1;
    fd0 = fd_cnt;
    b0  = beats;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) f[i] = 8'($urandom_range(0, 255));
      peak_of(f, em, eb);
      write_frame(f, 1'b0);
      check_peak(em, eb);
    end
    drain();
    rand_rd = 1'b0;
    bus.rd_ready = 1'b1;
    check("t3_fd_count", 32'(fd_cnt - fd0), 32'd4);
    check("t3_beats", 32'(beats - b0), 32'd32);

    // Back-to-back frames with no write bubble.
    fd0 = fd_cnt;
    for (int i = 0; i < 16; i++) begin
      write_bin(8'(i * 7 + 2), w);
      check("t4_no_bubble", 32'(w), 32'd0);
    end
    bus.wr_valid = 1'b0;
    drain();
    check("t4_fd_count", 32'(fd_cnt - fd0), 32'd2);

    // Reset mid-frame while the previous frame drains.
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) f[i] = 8'(8'h30 + i);
    write_frame(f, 1'b1);
    for (int i = 0; i < 4; i++) write_bin(8'(8'h50 + i), w);
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    b0 = beats;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    @(posedge clk);
    #1;
    check("t5_beats_before_rst", 32'(beats - b0), 32'd2);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h54;
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("t5_rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("t5_rst_rd_bin", 32'(bus.rd_bin), 32'd0);
    check("t5_rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("t5_rst_peak_mag", 32'(bus.peak_mag), 32'd0);
    check("t5_rst_peak_bin", 32'(bus.peak_bin), 32'd0);
    bus.wr_valid = 1'b0;
    sb.delete();
    fd0 = fd_cnt;
    repeat (3) begin
      @(negedge clk);
      check("t5_rst_frame_done", 32'(bus.frame_done), 32'd0);
      check("t5_rst_valid_hold", 32'(bus.rd_valid), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    f = '{default: 8'hFF};
    write_frame(f, 1'b0);
    check_peak(8'hFF, 3'd0);
    drain();
    f = '{8'd10, 8'd20, 8'd200, 8'd3, 8'd250, 8'd99, 8'd1, 8'hFE};
    write_frame(f, 1'b0);
    check_peak(8'hFE, 3'd7);
    drain();
    check("t5_fd_count", 32'(fd_cnt - fd0), 32'd2);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
